// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared arbiter state type, limits and index helpers.
package axis_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    localparam int AXIS_ARB_MAX_S_COUNT = 16;
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction
    function automatic int wrap_index(input int idx, input int n);
        return idx >= n ? idx - n : idx;
    endfunction
endpackage

// File: rtl/axis_frame_arbiter_if.sv
// axis_frame_arbiter_if: N packed AXI4-Stream lanes with producer/consumer modports.
interface axis_frame_arbiter_if #(
    parameter int N  = 1,
    parameter int DW = 8,
    parameter int UW = 1
);
    logic [N*DW-1:0] tdata;
    logic [N-1:0]    tvalid;
    logic [N-1:0]    tready;
    logic [N-1:0]    tlast;
    logic [N*UW-1:0] tuser;
    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_arb_select.sv
// axis_arb_select: rotate requests by ptr, pick lowest set bit, rotate the index back.
module axis_arb_select
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT   = 4,
    parameter int SEL_WIDTH = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0]   req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] idx,
    output logic                 found
);
    logic [S_COUNT-1:0]   rot;
    logic [SEL_WIDTH-1:0] k;
    always_comb begin
        rot = '0;
        k = '0;
        for (int i = 0; i < S_COUNT; i++) rot[i] = req[SEL_WIDTH'(wrap_index(i + int'(ptr), S_COUNT))];
        for (int i = S_COUNT - 1; i >= 0; i--) k = rot[i] ? SEL_WIDTH'(i) : k;
        found = |rot;
        idx = SEL_WIDTH'(wrap_index(int'(k) + int'(ptr), S_COUNT));
    end
endmodule

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-granular N:1 AXI4-Stream arbiter, grant held until tlast.
// Define AXIS_ARB_ROUND_ROBIN_EN for round-robin; default is fixed lowest-index priority.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int SEL_WIDTH  = $clog2(S_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_frame_arbiter_if.slave  s_axis,
    axis_frame_arbiter_if.master m_axis,
    output logic                 status_grant_valid,
    output logic [SEL_WIDTH-1:0] status_grant_index
);
    arb_state_t           state_q, state_d;
    logic [SEL_WIDTH-1:0] grant_q, grant_d, sel_idx, ptr;
    logic                 sel_found, granted, last_hs;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif
    axis_arb_select #(.S_COUNT(S_COUNT), .SEL_WIDTH(SEL_WIDTH)) u_select (
        .req  (s_axis.tvalid),
        .ptr  (ptr),
        .idx  (sel_idx),
        .found(sel_found)
    );
    always_comb begin
        granted = state_q == GRANT;
        m_axis.tdata = granted ? s_axis.tdata[slice_lo(int'(grant_q), DATA_WIDTH) +: DATA_WIDTH] : '0;
        m_axis.tuser = granted ? s_axis.tuser[slice_lo(int'(grant_q), USER_WIDTH) +: USER_WIDTH] : '0;
        m_axis.tvalid = granted & s_axis.tvalid[grant_q];
        m_axis.tlast = granted & s_axis.tlast[grant_q];
        s_axis.tready = granted ? S_COUNT'(m_axis.tready) << grant_q : '0;
        last_hs = m_axis.tvalid[0] & m_axis.tready[0] & m_axis.tlast[0];
        // requests arriving with the closing tlast wait for the following IDLE cycle
        state_d = granted ? (last_hs ? IDLE : GRANT) : (sel_found ? GRANT : IDLE);
        grant_d = !granted && sel_found ? sel_idx : grant_q;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
        ptr_d = granted && last_hs ? SEL_WIDTH'(wrap_index(int'(grant_q) + 1, S_COUNT)) : ptr_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
            ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
            ptr_q <= ptr_d;
`endif
        end
    end
    assign status_grant_valid = state_q == GRANT;
    assign status_grant_index = grant_q;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter: table vectors, directed corner sequences and a per-source beat scoreboard.
module tb_axis_frame_arbiter;
    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;
    typedef struct {
        logic [3:0] req;
        logic       gv;
        logic [1:0] fix;
        logic [1:0] rr;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gv;
    logic [1:0] gi;
    int         errors = 0;
    int         checks = 0;
    int         mon_beats = 0;
    int         seq[4];
    beat_t      sbq[4][$];
    beat_t      dq[4][$];
    int         flen[4][$];
    int         grant_log[$];
    bit         in_frame = 1'b0;
    int         cur_src = 0;
    int         mon_src;
    beat_t      mon_b;
    vec_t       tbl[9];
    int         exp_order[4];

    axis_frame_arbiter_if #(.N(4), .DW(8), .UW(1)) s_if ();
    axis_frame_arbiter_if #(.N(1), .DW(8), .UW(1)) m_if ();

    axis_frame_arbiter #(.S_COUNT(4), .DATA_WIDTH(8), .USER_WIDTH(1)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis            (s_if),
        .m_axis            (m_if),
        .status_grant_valid(gv),
        .status_grant_index(gi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input int s, input logic v, input logic [7:0] d, input logic l);
        s_if.tvalid[s] = v;
        s_if.tdata[s*8 +: 8] = d;
        s_if.tlast[s] = l;
        s_if.tuser[s] = d[0];
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic l);
        sbq[s].push_back(beat_t'{data: d, user: d[0], last: l});
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) set(i, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic reset_dut();
        chk("sb_leftover", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
        rst = 1'b1;
        clear_all();
        m_if.tready[0] = 1'b0;
        repeat (2) step();
        grant_log.delete();
        rst = 1'b0;
    endtask

    // Each source presents queued frames; frames are pushed to the scoreboard when generated.
    task automatic run_traffic(input int budget, input bit rnd);
        bit acc[4];
        int cyc;
        bit hold;
        cyc = 0;
        for (int i = 0; i < 4; i++) acc[i] = 1'b0;
        forever begin
            step();
            for (int i = 0; i < 4; i++) if (acc[i]) void'(dq[i].pop_front());
            if (dq[0].size() + dq[1].size() + dq[2].size() + dq[3].size() +
                flen[0].size() + flen[1].size() + flen[2].size() + flen[3].size() == 0) break;
            cyc++;
            if (cyc > budget) begin
                chk("traffic_timeout", cyc, budget);
                break;
            end
            for (int i = 0; i < 4; i++) begin
                if (dq[i].size() == 0 && flen[i].size() > 0) begin
                    int n;
                    n = flen[i].pop_front();
                    for (int b = 0; b < n; b++) begin
                        beat_t bt;
                        bt.data = {2'(i), 6'(seq[i])};
                        bt.user = bt.data[0];
                        bt.last = b == n - 1;
                        seq[i]++;
                        dq[i].push_back(bt);
                        sbq[i].push_back(bt);
                    end
                end
                hold = s_if.tvalid[i] && !acc[i];
                if (dq[i].size() == 0) set(i, 1'b0, 8'h00, 1'b0);
                else set(i, hold || !rnd || $urandom_range(3) != 0, dq[i][0].data, dq[i][0].last);
            end
            m_if.tready[0] = rnd ? ($urandom_range(3) != 0) : 1'b1;
            @(negedge clk);
            for (int i = 0; i < 4; i++) acc[i] = s_if.tvalid[i] && s_if.tready[i];
        end
        clear_all();
    endtask

    // Output monitor: the first beat of a frame names its source in tdata[7:6]; the rest must follow it.
    initial forever begin
        @(negedge clk);
        if (rst) in_frame = 1'b0;
        else if (m_if.tvalid[0] && m_if.tready[0]) begin
            mon_src = in_frame ? cur_src : int'(m_if.tdata[7:6]);
            if (!in_frame) grant_log.push_back(mon_src);
            chk("mon_grant_index", gi, mon_src);
            chk("sb_empty", sbq[mon_src].size() == 0, 0);
            if (sbq[mon_src].size() != 0) begin
                mon_b = sbq[mon_src].pop_front();
                chk("mon_beat", {m_if.tdata, m_if.tuser, m_if.tlast}, mon_b);
            end
            mon_beats++;
            in_frame = !m_if.tlast[0];
            cur_src = mon_src;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        int beats0;
        tbl[0] = '{4'b0000, 1'b0, 2'd0, 2'd0};
        tbl[1] = '{4'b0001, 1'b1, 2'd0, 2'd0};
        tbl[2] = '{4'b1010, 1'b1, 2'd1, 2'd1};
        tbl[3] = '{4'b1010, 1'b1, 2'd1, 2'd3};
        tbl[4] = '{4'b1100, 1'b1, 2'd2, 2'd2};
        tbl[5] = '{4'b0011, 1'b1, 2'd0, 2'd0};
        tbl[6] = '{4'b1111, 1'b1, 2'd0, 2'd1};
        tbl[7] = '{4'b1000, 1'b1, 2'd3, 2'd3};
        tbl[8] = '{4'b0110, 1'b1, 2'd1, 2'd1};
`ifdef AXIS_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 3, 0, 3};
`else
        exp_order = '{0, 0, 3, 3};
`endif
        for (int i = 0; i < 4; i++) seq[i] = 0;
        s_if.tvalid = '0;
        s_if.tdata = '0;
        s_if.tlast = '0;
        s_if.tuser = '0;
        m_if.tready[0] = 1'b1;
        set(1, 1'b1, 8'h55, 1'b1);
        repeat (2) step();
        chk("rst_grant_valid", gv, 0);
        chk("rst_grant_index", gi, 0);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_m_tvalid", m_if.tvalid[0], 0);
        chk("rst_m_tlast", m_if.tlast[0], 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_m_tuser", m_if.tuser, 0);
        rst = 1'b0;
        clear_all();

        // Single-beat frames from IDLE, one vector per arbitration decision.
        for (int r = 0; r < 9; r++) begin
            logic [1:0] e;
`ifdef AXIS_ARB_ROUND_ROBIN_EN
            e = tbl[r].rr;
`else
            e = tbl[r].fix;
`endif
            for (int i = 0; i < 4; i++) set(i, tbl[r].req[i], {2'(i), 6'(r)}, 1'b1);
            if (tbl[r].gv) push(int'(e), {e, 6'(r)}, 1'b1);
            #1;
            chk("tbl_idle_tvalid", m_if.tvalid[0], 0);
            step();
            chk("tbl_grant_valid", gv, tbl[r].gv);
            if (tbl[r].gv) begin
                chk("tbl_grant_index", gi, e);
                chk("tbl_s_tready", s_if.tready, 4'b0001 << e);
                chk("tbl_m_tdata", m_if.tdata, {e, 6'(r)});
                chk("tbl_m_tvalid", m_if.tvalid[0], 1);
            end
            step();
            clear_all();
            #1;
            chk("tbl_release", gv, 0);
        end

        // Single source, back-to-back frames: one IDLE cycle between them.
        reset_dut();
        m_if.tready[0] = 1'b1;
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        push(2, 8'hA4, 1'b1);
        set(2, 1'b1, 8'hA1, 1'b0);
        #1;
        chk("single_arb_cycle", gv, 0);
        step();
        chk("single_grant_valid", gv, 1);
        chk("single_grant_index", gi, 2);
        chk("single_beat1", m_if.tdata, 8'hA1);
        step();
        set(2, 1'b1, 8'hA2, 1'b0);
        step();
        set(2, 1'b1, 8'hA3, 1'b1);
        #1;
        chk("single_beat3_last", m_if.tlast[0], 1);
        step();
        set(2, 1'b1, 8'hA4, 1'b1);
        #1;
        chk("single_gap_idle", gv, 0);
        step();
        chk("single_regrant", gi, 2);
        chk("single_beat4", m_if.tdata, 8'hA4);
        step();
        clear_all();
        #1;
        chk("single_end_idle", gv, 0);

        // Contention between inputs 0 and 3, two 2-beat frames each.
        reset_dut();
        flen[0].push_back(2);
        flen[0].push_back(2);
        flen[3].push_back(2);
        flen[3].push_back(2);
        run_traffic(200, 1'b0);
        chk("contention_frames", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size() && k < 4; k++) chk("contention_order", grant_log[k], exp_order[k]);

        // Backpressure mid-frame on input 1 with input 0 waiting.
        reset_dut();
        m_if.tready[0] = 1'b1;
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b0);
        push(1, 8'h44, 1'b1);
        push(0, 8'h01, 1'b1);
        set(1, 1'b1, 8'h41, 1'b0);
        step();
        chk("bp_grant_index", gi, 1);
        step();
        set(1, 1'b1, 8'h42, 1'b0);
        set(0, 1'b1, 8'h01, 1'b1);
        m_if.tready[0] = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", gv, 1);
            chk("bp_hold_index", gi, 1);
            chk("bp_s_tready", s_if.tready, 0);
            chk("bp_m_tdata", m_if.tdata, 8'h42);
            step();
        end
        m_if.tready[0] = 1'b1;
        step();
        set(1, 1'b1, 8'h43, 1'b0);
        step();
        set(1, 1'b1, 8'h44, 1'b1);
        step();
        set(1, 1'b0, 8'h00, 1'b0);
        #1;
        chk("bp_gap", gv, 0);
        step();
        chk("bp_next_grant", gi, 0);
        step();
        clear_all();
        #1;
        chk("bp_end_idle", gv, 0);

        // Granted input 1 stalls for three cycles while input 2 waits.
        reset_dut();
        m_if.tready[0] = 1'b1;
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b0);
        push(1, 8'h44, 1'b1);
        push(2, 8'h81, 1'b1);
        set(1, 1'b1, 8'h41, 1'b0);
        step();
        chk("stall_grant_index", gi, 1);
        step();
        set(1, 1'b0, 8'h42, 1'b0);
        set(2, 1'b1, 8'h81, 1'b1);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_m_tvalid", m_if.tvalid[0], 0);
            chk("stall_grant_valid", gv, 1);
            chk("stall_grant_index", gi, 1);
            step();
        end
        set(1, 1'b1, 8'h42, 1'b0);
        step();
        set(1, 1'b1, 8'h43, 1'b0);
        step();
        set(1, 1'b1, 8'h44, 1'b1);
        step();
        set(1, 1'b0, 8'h00, 1'b0);
        #1;
        chk("stall_gap", gv, 0);
        step();
        chk("stall_next_grant", gi, 2);
        step();
        clear_all();

        // Reset in the middle of a 4-beat frame on input 3.
        reset_dut();
        m_if.tready[0] = 1'b1;
        push(1, 8'h41, 1'b1);
        set(1, 1'b1, 8'h41, 1'b1);
        step();
        step();
        set(1, 1'b0, 8'h00, 1'b0);
        push(3, 8'hC1, 1'b0);
        push(3, 8'hC2, 1'b0);
        push(3, 8'hC3, 1'b0);
        push(3, 8'hC4, 1'b1);
        set(3, 1'b1, 8'hC1, 1'b0);
        step();
        step();
        set(3, 1'b1, 8'hC2, 1'b0);
        step();
        set(3, 1'b1, 8'hC3, 1'b0);
        rst = 1'b1;
        step();
        chk("mrst_s_tready", s_if.tready, 0);
        chk("mrst_m_tvalid", m_if.tvalid[0], 0);
        chk("mrst_grant_valid", gv, 0);
        chk("mrst_grant_index", gi, 0);
        rst = 1'b0;
        clear_all();
        sbq[3].delete();
        push(1, 8'h42, 1'b1);
        set(1, 1'b1, 8'h42, 1'b1);
        set(3, 1'b1, 8'hC5, 1'b1);
        step();
        chk("ptr_after_reset", gi, 1);
        step();
        clear_all();
        #1;
        chk("mrst_end_idle", gv, 0);

        // Random traffic: 4 sources, frame lengths 1..8, about 10k beats.
        reset_dut();
        total = 0;
        while (total < 10000) begin
            int s;
            int n;
            s = $urandom_range(3);
            n = $urandom_range(8, 1);
            flen[s].push_back(n);
            total += n;
        end
        beats0 = mon_beats;
        run_traffic(60000, 1'b1);
        step();
        chk("rand_beat_count", mon_beats - beats0, total);
        chk("rand_frame_open", in_frame, 0);
        reset_dut();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
